// File: rtl/axis_selector_scheduler.sv
// Burst-based round-robin scheduler for the select line of a 2:1 AXI4-Stream selector.
// Observes the slave-side handshakes only and reports beat and switch counts.
module axis_selector_scheduler #(
    parameter int CNTR_WIDTH = 16,
    parameter int STS_WIDTH  = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cfg_enable,
    input  logic [CNTR_WIDTH-1:0] cfg_burst,
    input  logic [CNTR_WIDTH-1:0] cfg_timeout,
    input  logic                  s00_axis_tvalid,
    input  logic                  s00_axis_tready,
    input  logic                  s01_axis_tvalid,
    input  logic                  s01_axis_tready,
    output logic                  sel_data,
    output logic [STS_WIDTH-1:0]  sts_beats0,
    output logic [STS_WIDTH-1:0]  sts_beats1,
    output logic [STS_WIDTH-1:0]  sts_switches
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t                state_q;
    logic                  sel_q;
    logic                  last_grant_q;
    logic [CNTR_WIDTH-1:0] beat_cnt_q;
    logic [CNTR_WIDTH-1:0] idle_cnt_q;
    logic [STS_WIDTH-1:0]  beats0_q;
    logic [STS_WIDTH-1:0]  beats1_q;
    logic [STS_WIDTH-1:0]  switches_q;

    logic                  hs0;
    logic                  hs1;
    logic                  granted;
    logic                  grant_id;
    logic                  hs_granted;
    logic                  other_valid;
    logic                  idle_pick;
    logic [CNTR_WIDTH-1:0] beat_inc_d;
    logic [CNTR_WIDTH-1:0] idle_inc_d;
    logic [CNTR_WIDTH:0]   burst_eff;
    logic                  burst_done;
    logic                  timeout_hit;
    logic                  switch_d;

    assign hs0 = s00_axis_tvalid & s00_axis_tready;
    assign hs1 = s01_axis_tvalid & s01_axis_tready;

    assign granted     = (state_q == GRANT0) || (state_q == GRANT1);
    assign grant_id    = (state_q == GRANT1);
    assign hs_granted  = grant_id ? hs1 : hs0;
    assign other_valid = grant_id ? s00_axis_tvalid : s01_axis_tvalid;

    // With both sources requesting, the one not served last wins.
    assign idle_pick = (s00_axis_tvalid & s01_axis_tvalid) ? ~last_grant_q : s01_axis_tvalid;

    assign beat_inc_d = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + CNTR_WIDTH'(1);
    assign idle_inc_d = (&idle_cnt_q) ? idle_cnt_q : idle_cnt_q + CNTR_WIDTH'(1);

    // Compares are one bit wider so beat/idle +1 cannot wrap at all-ones.
    assign burst_eff   = (cfg_burst == '0) ? (CNTR_WIDTH+1)'(1) : {1'b0, cfg_burst};
    assign burst_done  = ({1'b0, beat_cnt_q} + (CNTR_WIDTH+1)'(1)) >= burst_eff;
    assign timeout_hit = (cfg_timeout != '0) &&
                         (({1'b0, idle_cnt_q} + (CNTR_WIDTH+1)'(1)) >= {1'b0, cfg_timeout});

    assign switch_d = cfg_enable && granted && other_valid &&
                      ((hs_granted && burst_done) || (!hs_granted && timeout_hit));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            idle_cnt_q   <= '0;
        end else if (!cfg_enable) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    beat_cnt_q <= '0;
                    idle_cnt_q <= '0;
                    if (s00_axis_tvalid || s01_axis_tvalid) begin
                        state_q      <= idle_pick ? GRANT1 : GRANT0;
                        sel_q        <= idle_pick;
                        last_grant_q <= idle_pick;
                    end
                end
                GRANT0, GRANT1: begin
                    if (switch_d) begin
                        state_q      <= grant_id ? GRANT0 : GRANT1;
                        sel_q        <= ~grant_id;
                        last_grant_q <= ~grant_id;
                        beat_cnt_q   <= '0;
                        idle_cnt_q   <= '0;
                    end else if (hs_granted) begin
                        idle_cnt_q <= '0;
                        beat_cnt_q <= burst_done ? '0 : beat_inc_d;
                    end else begin
                        idle_cnt_q <= idle_inc_d;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    beat_cnt_q <= '0;
                    idle_cnt_q <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            beats0_q   <= '0;
            beats1_q   <= '0;
            switches_q <= '0;
        end else begin
            if (hs0)      beats0_q   <= beats0_q + STS_WIDTH'(1);
            if (hs1)      beats1_q   <= beats1_q + STS_WIDTH'(1);
            if (switch_d) switches_q <= switches_q + STS_WIDTH'(1);
        end
    end

    assign sel_data     = sel_q;
    assign sts_beats0   = beats0_q;
    assign sts_beats1   = beats1_q;
    assign sts_switches = switches_q;

endmodule

// File: tb/tb_axis_selector_scheduler.sv
// Scoreboarded bench for axis_selector_scheduler: directed scenarios plus random traffic
// checked against a rule-level model of the grant/burst/timeout behaviour.
module tb_axis_selector_scheduler;

    localparam int CW = 16;
    localparam int SW = 32;

    logic          aclk = 1'b0;
    logic          areset;
    logic          cfg_enable;
    logic [CW-1:0] cfg_burst;
    logic [CW-1:0] cfg_timeout;
    logic          v0, r0, v1, r1;
    logic          sel_data;
    logic [SW-1:0] sts_beats0, sts_beats1, sts_switches;

    axis_selector_scheduler #(.CNTR_WIDTH(CW), .STS_WIDTH(SW)) dut (
        .aclk            (aclk),
        .areset          (areset),
        .cfg_enable      (cfg_enable),
        .cfg_burst       (cfg_burst),
        .cfg_timeout     (cfg_timeout),
        .s00_axis_tvalid (v0),
        .s00_axis_tready (r0),
        .s01_axis_tvalid (v1),
        .s01_axis_tready (r1),
        .sel_data        (sel_data),
        .sts_beats0      (sts_beats0),
        .sts_beats1      (sts_beats1),
        .sts_switches    (sts_switches)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic          sel;
        logic [SW-1:0] b0;
        logic [SW-1:0] b1;
        logic [SW-1:0] sw;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    int   txn      = 0;

    // Reference model: owner -1 means nobody holds the port.
    int            m_owner;
    int            m_last;
    logic          m_sel;
    int            m_used;
    int            m_stall;
    logic [SW-1:0] m_b0, m_b1, m_sw;

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_sel   = 1'b0;
        m_used  = 0;
        m_stall = 0;
        m_b0    = '0;
        m_b1    = '0;
        m_sw    = '0;
    endtask

    task automatic model_give(input int who, input bit counted);
        m_owner = who;
        m_last  = who;
        m_sel   = (who == 1);
        m_used  = 0;
        m_stall = 0;
        if (counted) m_sw = m_sw + 1;
    endtask

    task automatic model_step(input bit en, input int burst, input int tmo,
                              input bit a0, input bit a1, input bit k0, input bit k1);
        int limit;
        bit mine_hs, other_v;
        if (a0 && k0) m_b0 = m_b0 + 1;
        if (a1 && k1) m_b1 = m_b1 + 1;
        limit = (burst == 0) ? 1 : burst;
        if (!en) begin
            m_owner = -1;
            m_used  = 0;
            m_stall = 0;
        end else if (m_owner < 0) begin
            if (a0 && a1)  model_give(1 - m_last, 1'b0);
            else if (a0)   model_give(0, 1'b0);
            else if (a1)   model_give(1, 1'b0);
        end else begin
            mine_hs = (m_owner == 0) ? (a0 && k0) : (a1 && k1);
            other_v = (m_owner == 0) ? a1 : a0;
            if (mine_hs) begin
                m_stall = 0;
                m_used++;
                if (m_used >= limit) begin
                    m_used = 0;
                    if (other_v) model_give(1 - m_owner, 1'b1);
                end
            end else begin
                m_stall++;
                if (tmo != 0 && m_stall >= tmo && other_v) model_give(1 - m_owner, 1'b1);
            end
        end
    endtask

    // One clock of stimulus: drive at the falling edge, predict the next rising edge.
    task automatic cycle(input bit en, input int burst, input int tmo,
                         input bit nv0, input bit nv1, input bit nr);
        exp_t e;
        @(negedge aclk);
        cfg_enable  = en;
        cfg_burst   = CW'(burst);
        cfg_timeout = CW'(tmo);
        v0 = nv0;
        v1 = nv1;
        r0 = nr & ~m_sel;
        r1 = nr & m_sel;
        model_step(en, burst, tmo, v0, v1, r0, r1);
        e.sel = m_sel;
        e.b0  = m_b0;
        e.b1  = m_b1;
        e.sw  = m_sw;
        q.push_back(e);
    endtask

    always @(posedge aclk) begin
        exp_t e;
        #1;
        if (mon_en) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got 0 entries, expected at least 1");
            end else begin
                e = q.pop_front();
                txn++;
                $display("txn %0d: sel=%0d b0=%0d b1=%0d sw=%0d (exp sel=%0d b0=%0d b1=%0d sw=%0d)",
                         txn, sel_data, sts_beats0, sts_beats1, sts_switches, e.sel, e.b0, e.b1, e.sw);
                check("sel_data", SW'(sel_data), SW'(e.sel));
                check("sts_beats0", sts_beats0, e.b0);
                check("sts_beats1", sts_beats1, e.b1);
                check("sts_switches", sts_switches, e.sw);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_sel"}, SW'(sel_data), SW'(0));
        check({tag, "_beats0"}, sts_beats0, SW'(0));
        check({tag, "_beats1"}, sts_beats1, SW'(0));
        check({tag, "_switches"}, sts_switches, SW'(0));
    endtask

    initial begin
        int burst, tmo;
        areset = 1'b1;
        cfg_enable = 1'b0;
        cfg_burst = '0;
        cfg_timeout = '0;
        v0 = 1'b0; v1 = 1'b0; r0 = 1'b0; r1 = 1'b0;
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        check_reset_values("reset");
        @(posedge aclk);
        #3;
        areset = 1'b0;
        mon_en = 1'b1;

        // Toggling bursts of 4 with both sources always valid.
        for (int i = 0; i < 40; i++) cycle(1, 4, 0, 1, 1, 1);

        // Timeout: s00 gives two beats then drops, s01 is waiting.
        cycle(0, 8, 3, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 8, 3, 1, 0, 1);
        for (int i = 0; i < 8; i++) cycle(1, 8, 3, 0, 1, 1);

        // Single source s01 with burst of 2.
        cycle(0, 2, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(1, 2, 0, 0, 1, 1);

        // Burst of zero behaves as one.
        for (int i = 0; i < 12; i++) cycle(1, 0, 0, 1, 1, 1);

        // Disable mid-burst, then re-enable with both valid.
        for (int i = 0; i < 6; i++) cycle(1, 4, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 4, 0, 1, 1, 1);
        for (int i = 0; i < 8; i++) cycle(1, 4, 0, 1, 1, 1);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 5; i++) cycle(1, 8, 0, 1, 1, 1);
        @(posedge aclk);
        #3;
        mon_en = 1'b0;
        areset = 1'b1;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(posedge aclk);
        #3;
        areset = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) cycle(1, 3, 0, 1, 1, 1);

        // Random traffic with shifting configuration.
        burst = 3;
        tmo = 2;
        for (int i = 0; i < 2000; i++) begin
            if (i % 60 == 0) begin
                burst = $urandom_range(0, 5);
                tmo   = $urandom_range(0, 4);
            end
            cycle(($urandom_range(0, 19) != 0), burst, tmo,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0));
        end

        @(posedge aclk);
        #2;
        check("scoreboard_drained", SW'(q.size()), SW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
